// File: rtl/muldiv_pkg.sv
// Shared encodings and widths for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    // start is taken only while busy is low (IDLE or DONE); done/hilo_we pulse for
    // exactly one cycle with hi_out/lo_out valid. cancel beats start in the same cycle.
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic              busy;
    logic              done;
    logic              hilo_we;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              div_zero;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, hilo_we, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, hilo_we, hi_out, lo_out, div_zero
    );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step: shift-add multiply or restoring shift-subtract divide
// on a {hi, lo} accumulator.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   operand,
    input  logic                is_div,
    output logic [2*DATA_W-1:0] acc_next
);

    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] trial;

    always_comb begin
        add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
        // Shifted remainder needs 33 bits; bit DATA_W of the difference is the borrow.
        trial   = acc[2*DATA_W-1:DATA_W-1] - {1'b0, operand};
        if (is_div) begin
            if (trial[DATA_W]) begin
                acc_next = {acc[2*DATA_W-2:0], 1'b0};
            end else begin
                acc_next = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_next = {add_sum, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step MULT/MULTU/DIV/DIVU unit with HI/LO result registers,
// fixed 33-edge latency, cancel and busy for pipeline stalls.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus,
    output state_t   state_dbg
);

    localparam logic [5:0] LAST = 6'(ITER);

    state_t              state, state_next;
    logic [5:0]          count;
    logic [2*DATA_W-1:0] acc, acc_next, prod;
    logic [DATA_W-1:0]   operand;
    logic                is_div, neg_res, neg_a, b_zero;
    logic [DATA_W-1:0]   hi_q, lo_q, res_hi, res_lo;
    logic                div_zero_q;
    logic                accept, sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b;

    assign accept = bus.start && !bus.cancel && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.cancel) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_next = S_RUN;
                S_RUN:   if (count == LAST) state_next = S_DONE;
                S_DONE:  state_next = bus.start ? S_RUN : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (state == S_RUN);
        bus.done    = (state == S_DONE);
        bus.hilo_we = (state == S_DONE);
    end

    always_comb begin
        sign_a = bus.op[0] & bus.src_a[DATA_W-1];
        sign_b = bus.op[0] & bus.src_b[DATA_W-1];
        mag_a  = cond_neg(sign_a, bus.src_a);
        mag_b  = cond_neg(sign_b, bus.src_b);
    end

    muldiv_iter u_iter (
        .acc      (acc),
        .operand  (operand),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    // After a divide by zero the accumulator remainder equals |a|, so the usual
    // remainder sign fix restores src_a exactly; only the quotient is forced.
    always_comb begin
        prod = neg_res ? (~acc + 1'b1) : acc;
        if (is_div) begin
            res_hi = cond_neg(neg_a, acc[2*DATA_W-1:DATA_W]);
            res_lo = b_zero ? '1 : cond_neg(neg_res, acc[DATA_W-1:0]);
        end else begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            acc        <= '0;
            operand    <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_a      <= 1'b0;
            b_zero     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            count      <= '0;
            acc        <= {{DATA_W{1'b0}}, mag_a};
            operand    <= mag_b;
            is_div     <= bus.op[1];
            neg_res    <= sign_a ^ sign_b;
            neg_a      <= sign_a;
            b_zero     <= (bus.src_b == '0);
            div_zero_q <= 1'b0;
        end else if (state == S_RUN && !bus.cancel) begin
            if (count != LAST) begin
                acc   <= acc_next;
                count <= count + 6'd1;
            end else begin
                hi_q       <= res_hi;
                lo_q       <= res_lo;
                div_zero_q <= is_div & b_zero;
            end
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.div_zero = div_zero_q;
    assign state_dbg    = state;

endmodule
